pipe_hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the 4-stage pipelined MIPS core (ID, EX, MEM, WB). The current pipeline has no hazard handling and needs NOPs in code; this block replaces that.
It tracks destination-register metadata for EX/MEM/WB, generates registered forwarding selects for the EX operand muxes, and inserts stalls for load-use and multi-cycle multiply. It also supports a flush input for control-flow redirects.

---
 rtl/pipe_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and forwarding controller for the 4-stage MIPS pipeline (ID, EX, MEM, WB).
// It tracks destination-register metadata for the EX, MEM and WB stages and
// registers the forwarding selects used by the EX operand muxes. It stalls the
// front end on a load-use hazard and while a multi-cycle multiply occupies EX.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-low reset
//   id_*         decoded metadata of the instruction currently in ID
//   flush        kill the instruction leaving ID (control-flow redirect)
//   wb_data      value on the write-back bus this cycle
//   stall        freeze PC, IF and ID (combinational)
//   ex_hold      freeze the EX input registers (combinational)
//   ex_fwd_a_sel EX operand A select: 0 RF, 1 d_mem, 2 write_back, 3 hold_data
//   ex_fwd_b_sel same encoding for operand B
//   hold_data    captured write-back value used by select 3
//   stage_valid  {ex, mem, wb} valid bits
module pipe_hazard_ctrl #(
   parameter int REG_W      = 5,
   parameter int DATA_W     = 32,
   parameter int MUL_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_a_reg,
   input  logic [REG_W-1:0]  id_b_reg,
   input  logic              id_uses_a,
   input  logic              id_uses_b,
   input  logic              id_wb_en,
   input  logic [REG_W-1:0]  id_wb_reg,
   input  logic              id_is_load,
   input  logic              id_is_mul,
   input  logic              flush,
   input  logic [DATA_W-1:0] wb_data,
   output logic              stall,
   output logic              ex_hold,
   output logic [1:0]        ex_fwd_a_sel,
   output logic [1:0]        ex_fwd_b_sel,
   output logic [DATA_W-1:0] hold_data,
   output logic [2:0]        stage_valid
);

   localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

   // A producer in a stage matches a consumer source when it really writes
   // back to that register, the source is actually read, and it is not r0.
   function automatic logic src_match(input logic vld, input logic wb_en,
                                      input logic [REG_W-1:0] rd,
                                      input logic [REG_W-1:0] src,
                                      input logic uses);
      return vld && wb_en && uses && (src != '0) && (rd == src);
   endfunction

   // Youngest producer wins: EX result sits in d_mem next cycle, MEM result
   // is on write_back next cycle, WB result is only visible through hold_data.
   function automatic logic [1:0] fwd_sel(input logic live, input logic m_ex,
                                          input logic m_mem, input logic m_wb);
      if (!live)      return 2'd0;
      else if (m_ex)  return 2'd1;
      else if (m_mem) return 2'd2;
      else if (m_wb)  return 2'd3;
      else            return 2'd0;
   endfunction

   logic             vld_p0, wb_en_p0, is_load_p0;
   logic [REG_W-1:0] wb_reg_p0;
   logic             vld_p1, wb_en_p1;
   logic [REG_W-1:0] wb_reg_p1;
   logic             vld_p2, wb_en_p2;
   logic [REG_W-1:0] wb_reg_p2;
   logic [3:0]       mul_cnt;
   logic             flush_pend;

   logic       mul_busy, flush_eff, id_live, load_use;
   logic       a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
   logic [1:0] sel_a_nxt, sel_b_nxt;

   always_comb begin
      mul_busy  = (mul_cnt != 4'd0);
      // A flush seen while the multiply holds ID is remembered and applied
      // when that instruction finally advances.
      flush_eff = flush | flush_pend;
      id_live   = id_valid & ~flush_eff;
      a_ex  = src_match(vld_p0, wb_en_p0, wb_reg_p0, id_a_reg, id_uses_a);
      a_mem = src_match(vld_p1, wb_en_p1, wb_reg_p1, id_a_reg, id_uses_a);
      a_wb  = src_match(vld_p2, wb_en_p2, wb_reg_p2, id_a_reg, id_uses_a);
      b_ex  = src_match(vld_p0, wb_en_p0, wb_reg_p0, id_b_reg, id_uses_b);
      b_mem = src_match(vld_p1, wb_en_p1, wb_reg_p1, id_b_reg, id_uses_b);
      b_wb  = src_match(vld_p2, wb_en_p2, wb_reg_p2, id_b_reg, id_uses_b);
      load_use  = id_live & is_load_p0 & (a_ex | b_ex);
      sel_a_nxt = fwd_sel(id_live, a_ex, a_mem, a_wb);
      sel_b_nxt = fwd_sel(id_live, b_ex, b_mem, b_wb);
      stall     = mul_busy | load_use;
      ex_hold   = mul_busy;
   end

   assign stage_valid = {vld_p0, vld_p1, vld_p2};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p0       <= 1'b0;
         wb_en_p0     <= 1'b0;
         wb_reg_p0    <= '0;
         is_load_p0   <= 1'b0;
         vld_p1       <= 1'b0;
         wb_en_p1     <= 1'b0;
         wb_reg_p1    <= '0;
         vld_p2       <= 1'b0;
         wb_en_p2     <= 1'b0;
         wb_reg_p2    <= '0;
         mul_cnt      <= 4'd0;
         flush_pend   <= 1'b0;
         ex_fwd_a_sel <= 2'd0;
         ex_fwd_b_sel <= 2'd0;
         hold_data    <= '0;
      end else begin
         // MEM -> WB always advances
         vld_p2    <= vld_p1;
         wb_en_p2  <= wb_en_p1;
         wb_reg_p2 <= wb_reg_p1;
         if (mul_busy) begin
            // EX retained by the multiply, MEM receives a bubble
            mul_cnt    <= mul_cnt - 4'd1;
            vld_p1     <= 1'b0;
            flush_pend <= flush_eff;
         end else begin
            flush_pend <= 1'b0;
            // EX -> MEM
            vld_p1    <= vld_p0;
            wb_en_p1  <= wb_en_p0;
            wb_reg_p1 <= wb_reg_p0;
            if (load_use) begin
               vld_p0       <= 1'b0;
               ex_fwd_a_sel <= 2'd0;
               ex_fwd_b_sel <= 2'd0;
            end else begin
               // ID -> EX
               vld_p0       <= id_live;
               wb_en_p0     <= id_wb_en;
               wb_reg_p0    <= id_wb_reg;
               is_load_p0   <= id_is_load;
               ex_fwd_a_sel <= sel_a_nxt;
               ex_fwd_b_sel <= sel_b_nxt;
               if (sel_a_nxt == 2'd3 || sel_b_nxt == 2'd3)
                  hold_data <= wb_data;
               if (id_live && id_is_mul)
                  mul_cnt <= MUL_LOAD;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
   localparam int REG_W      = 5;
   localparam int DATA_W     = 32;
   localparam int MUL_CYCLES = 4;

   logic              clk, rst;
   logic              id_valid, id_uses_a, id_uses_b, id_wb_en, id_is_load, id_is_mul, flush;
   logic [REG_W-1:0]  id_a_reg, id_b_reg, id_wb_reg;
   logic [DATA_W-1:0] wb_data;
   logic              stall, ex_hold;
   logic [1:0]        ex_fwd_a_sel, ex_fwd_b_sel;
   logic [DATA_W-1:0] hold_data;
   logic [2:0]        stage_valid;

   int n_checks = 0;
   int n_fail   = 0;

   pipe_hazard_ctrl #(.REG_W(REG_W), .DATA_W(DATA_W), .MUL_CYCLES(MUL_CYCLES)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_a_reg(id_a_reg), .id_b_reg(id_b_reg),
      .id_uses_a(id_uses_a), .id_uses_b(id_uses_b), .id_wb_en(id_wb_en), .id_wb_reg(id_wb_reg),
      .id_is_load(id_is_load), .id_is_mul(id_is_mul), .flush(flush), .wb_data(wb_data),
      .stall(stall), .ex_hold(ex_hold), .ex_fwd_a_sel(ex_fwd_a_sel), .ex_fwd_b_sel(ex_fwd_b_sel),
      .hold_data(hold_data), .stage_valid(stage_valid));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: list of in-flight instructions by distance from ID
   typedef struct packed {
      logic             valid;
      logic             wb_en;
      logic [REG_W-1:0] rd;
      logic             ld;
   } ent_t;

   ent_t        m_pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
   int          m_mul_left;
   logic [1:0]  m_sel_a, m_sel_b;
   logic [31:0] m_hold;

   function automatic int producer_dist(input logic [REG_W-1:0] src, input logic uses);
      if (!uses || src == 0) return 0;
      for (int k = 0; k < 3; k++)
         if (m_pipe[k].valid && m_pipe[k].wb_en && m_pipe[k].rd == src) return k + 1;
      return 0;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [REG_W-1:0] a, input logic [REG_W-1:0] b,
                         input logic ua, input logic ub, input logic we,
                         input logic [REG_W-1:0] rd, input logic ld, input logic ml);
      id_valid = v; id_a_reg = a; id_b_reg = b; id_uses_a = ua; id_uses_b = ub;
      id_wb_en = we; id_wb_reg = rd; id_is_load = ld; id_is_mul = ml;
   endtask

   task automatic idle;
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      flush = 1'b0;
   endtask

   task automatic drain;
      idle();
      repeat (4) tick();
   endtask

   task automatic test_reset;
      rst = 1'b0;
      idle();
      wb_data = 32'h0;
      #2;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall); end
      n_checks++; if (ex_hold !== 1'b0) begin n_fail++; $display("FAIL reset_ex_hold: got %0b want 0", ex_hold); end
      repeat (2) tick();
      n_checks++; if (ex_fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel_a: got %0d want 0", ex_fwd_a_sel); end
      n_checks++; if (ex_fwd_b_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel_b: got %0d want 0", ex_fwd_b_sel); end
      n_checks++; if (hold_data !== 32'h0) begin n_fail++; $display("FAIL reset_hold: got %h want 0", hold_data); end
      n_checks++; if (stage_valid !== 3'b000) begin n_fail++; $display("FAIL reset_stage_valid: got %b want 000", stage_valid); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back;
      drain();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);   // add r3 <- r1, r2
      tick();
      set_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);   // add r4 <- r3, r5
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got %0b want 0", stall); end
      tick();
      n_checks++; if (ex_fwd_a_sel !== 2'd1) begin n_fail++; $display("FAIL b2b_sel_a: got %0d want 1", ex_fwd_a_sel); end
      n_checks++; if (ex_fwd_b_sel !== 2'd0) begin n_fail++; $display("FAIL b2b_sel_b: got %0d want 0", ex_fwd_b_sel); end
      n_checks++; if (stage_valid !== 3'b110) begin n_fail++; $display("FAIL b2b_stage_valid: got %b want 110", stage_valid); end
   endtask

   task automatic test_distance;
      drain();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);   // producer of r3
      tick();
      idle();
      tick();
      set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);   // distance 2
      tick();
      n_checks++; if (ex_fwd_a_sel !== 2'd2) begin n_fail++; $display("FAIL dist2_sel_a: got %0d want 2", ex_fwd_a_sel); end
      drain();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
      tick();
      idle();
      tick();
      tick();
      set_id(1'b1, 5'd6, 5'd3, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);   // distance 3, on B
      wb_data = 32'hDEADBEEF;
      tick();
      wb_data = 32'h12345678;
      n_checks++; if (ex_fwd_b_sel !== 2'd3) begin n_fail++; $display("FAIL dist3_sel_b: got %0d want 3", ex_fwd_b_sel); end
      n_checks++; if (ex_fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL dist3_sel_a: got %0d want 0", ex_fwd_a_sel); end
      n_checks++; if (hold_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL dist3_hold: got %h want deadbeef", hold_data); end
   endtask

   task automatic test_load_use;
      drain();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0);   // lw r2
      tick();
      set_id(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);   // add r6 <- r2, r2
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %0b want 1", stall); end
      n_checks++; if (ex_hold !== 1'b0) begin n_fail++; $display("FAIL lu_ex_hold: got %0b want 0", ex_hold); end
      tick();
      n_checks++; if (stage_valid !== 3'b010) begin n_fail++; $display("FAIL lu_bubble_ex: got %b want 010", stage_valid); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_once: got %0b want 0", stall); end
      tick();
      n_checks++; if (ex_fwd_a_sel !== 2'd2) begin n_fail++; $display("FAIL lu_sel_a: got %0d want 2", ex_fwd_a_sel); end
      n_checks++; if (ex_fwd_b_sel !== 2'd2) begin n_fail++; $display("FAIL lu_sel_b: got %0d want 2", ex_fwd_b_sel); end
      n_checks++; if (stage_valid !== 3'b101) begin n_fail++; $display("FAIL lu_bubble_mem: got %b want 101", stage_valid); end
   endtask

   task automatic test_multiply;
      int stall_cycles;
      drain();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1);   // mul r7
      tick();
      set_id(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);   // add r8 <- r7, r1
      stall_cycles = 0;
      #1;
      for (int i = 0; i < 10 && stall; i++) begin
         stall_cycles++;
         n_checks++; if (ex_hold !== 1'b1) begin n_fail++; $display("FAIL mul_ex_hold: got %0b want 1", ex_hold); end
         tick();
         #1;
      end
      n_checks++; if (stall_cycles != MUL_CYCLES - 1) begin n_fail++; $display("FAIL mul_stall_len: got %0d want %0d", stall_cycles, MUL_CYCLES - 1); end
      n_checks++; if (stage_valid !== 3'b100) begin n_fail++; $display("FAIL mul_mem_bubble: got %b want 100", stage_valid); end
      tick();
      n_checks++; if (ex_fwd_a_sel !== 2'd1) begin n_fail++; $display("FAIL mul_sel_a: got %0d want 1", ex_fwd_a_sel); end
      n_checks++; if (ex_fwd_b_sel !== 2'd0) begin n_fail++; $display("FAIL mul_sel_b: got %0d want 0", ex_fwd_b_sel); end
   endtask

   task automatic test_r0;
      drain();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);   // lw r0
      tick();
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);   // add r4 <- r0, r0
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %0b want 0", stall); end
      tick();
      n_checks++; if (ex_fwd_a_sel !== 2'd0 || ex_fwd_b_sel !== 2'd0) begin
         n_fail++; $display("FAIL r0_sel: got %0d/%0d want 0/0", ex_fwd_a_sel, ex_fwd_b_sel);
      end
   endtask

   task automatic test_flush;
      int stall_cycles;
      drain();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1);   // mul r7
      tick();
      set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0);  // to be flushed
      flush = 1'b1;
      stall_cycles = 0;
      #1;
      for (int i = 0; i < 10 && stall; i++) begin
         stall_cycles++;
         tick();
         flush = 1'b0;
         #1;
      end
      n_checks++; if (stall_cycles != MUL_CYCLES - 1) begin n_fail++; $display("FAIL flush_mul_len: got %0d want %0d", stall_cycles, MUL_CYCLES - 1); end
      tick();
      n_checks++; if (stage_valid !== 3'b010) begin n_fail++; $display("FAIL flush_ex_valid: got %b want 010", stage_valid); end
      n_checks++; if (ex_fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL flush_sel_a: got %0d want 0", ex_fwd_a_sel); end
      flush = 1'b1;                                                     // plain flush, no stall
      tick();
      flush = 1'b0;
      n_checks++; if (stage_valid[2] !== 1'b0) begin n_fail++; $display("FAIL flush_plain: got %b want 0xx", stage_valid); end
   endtask

   task automatic test_reset_mid_stall;
      drain();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1);
      tick();
      set_id(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
      tick();
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_stall: got %0b want 1", stall); end
      #1 rst = 1'b0;
      #1;
      n_checks++; if (stall !== 1'b0 || ex_hold !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %0b/%0b want 0/0", stall, ex_hold); end
      n_checks++; if (hold_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid_hold: got %h want 0", hold_data); end
      n_checks++; if (stage_valid !== 3'b000 || ex_fwd_a_sel !== 2'd0) begin
         n_fail++; $display("FAIL rst_mid_state: got %b/%0d want 000/0", stage_valid, ex_fwd_a_sel);
      end
      idle();
      tick();
      rst = 1'b1;
      test_back_to_back();
   endtask

   task automatic test_random;
      logic live, lu, e_stall, e_hold, was_stall;
      int   da, db;
      drain();
      rst = 1'b0;
      #1 rst = 1'b1;
      for (int k = 0; k < 3; k++) m_pipe[k] = '0;
      m_mul_left = 0; m_sel_a = 2'd0; m_sel_b = 2'd0; m_hold = 32'h0;
      was_stall = 1'b0;
      tick();
      for (int i = 0; i < 400; i++) begin
         if (!was_stall) begin
            set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
         end
         flush   = (m_mul_left == 0) && ($urandom_range(0, 9) == 0);
         wb_data = $urandom;
         #1;
         live    = id_valid && !flush;
         da      = producer_dist(id_a_reg, id_uses_a);
         db      = producer_dist(id_b_reg, id_uses_b);
         lu      = live && m_pipe[0].valid && m_pipe[0].ld && (da == 1 || db == 1);
         e_hold  = (m_mul_left > 0);
         e_stall = e_hold || lu;
         n_checks++; if (stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall cyc %0d: got %0b want %0b", i, stall, e_stall); end
         n_checks++; if (ex_hold !== e_hold) begin n_fail++; $display("FAIL rnd_ex_hold cyc %0d: got %0b want %0b", i, ex_hold, e_hold); end
         m_pipe[2] = m_pipe[1];
         if (m_mul_left > 0) begin
            m_pipe[1].valid = 1'b0;
            m_mul_left--;
         end else begin
            m_pipe[1] = m_pipe[0];
            if (lu) begin
               m_pipe[0].valid = 1'b0;
               m_sel_a = 2'd0; m_sel_b = 2'd0;
            end else begin
               m_pipe[0] = '{valid: live, wb_en: id_wb_en, rd: id_wb_reg, ld: id_is_load};
               m_sel_a = live ? 2'(da) : 2'd0;
               m_sel_b = live ? 2'(db) : 2'd0;
               if (m_sel_a == 2'd3 || m_sel_b == 2'd3) m_hold = wb_data;
               if (live && id_is_mul) m_mul_left = MUL_CYCLES - 1;
            end
         end
         was_stall = e_stall;
         tick();
         n_checks++; if (ex_fwd_a_sel !== m_sel_a) begin n_fail++; $display("FAIL rnd_sel_a cyc %0d: got %0d want %0d", i, ex_fwd_a_sel, m_sel_a); end
         n_checks++; if (ex_fwd_b_sel !== m_sel_b) begin n_fail++; $display("FAIL rnd_sel_b cyc %0d: got %0d want %0d", i, ex_fwd_b_sel, m_sel_b); end
         n_checks++; if (hold_data !== m_hold) begin n_fail++; $display("FAIL rnd_hold cyc %0d: got %h want %h", i, hold_data, m_hold); end
         n_checks++; if (stage_valid !== {m_pipe[0].valid, m_pipe[1].valid, m_pipe[2].valid}) begin
            n_fail++; $display("FAIL rnd_stage_valid cyc %0d: got %b want %b", i, stage_valid,
                               {m_pipe[0].valid, m_pipe[1].valid, m_pipe[2].valid});
         end
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_distance();
      test_load_use();
      test_multiply();
      test_r0();
      test_flush();
      test_reset_mid_stall();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
